// File: rtl/dsp_cfg_sequencer.sv
// dsp_cfg_sequencer: sits between the control register file and dsp_engine.
// It glides volume one step per input sample and sequences OSR changes
// click-free: mute, wait for the gain ramp to reach 0, switch, flush, unmute.
module dsp_cfg_sequencer #(
    parameter int          RAMP_CYCLES   = 512,
    parameter int          SETTLE_CYCLES = 32,
    parameter int          VOL_STEP      = 256,
    parameter logic [15:0] RESET_VOL     = 16'h7FFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [3:0]  cfg_osr,
    input  logic [15:0] cfg_volume,
    input  logic        cfg_mute,
    input  logic        sample_tick,
    output logic [3:0]  osr_sel,
    output logic [15:0] volume_q15,
    output logic        soft_mute,
    output logic        busy,
    output logic        done
);

    localparam int MCW = $clog2(RAMP_CYCLES + 1);
    localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [MCW-1:0] RAMP_MAX    = MCW'(RAMP_CYCLES);
    localparam logic [SCW-1:0] SETTLE_LOAD = SCW'(SETTLE_CYCLES - 1);
    localparam logic [16:0]    STEP17      = 17'(VOL_STEP);
    localparam logic [15:0]    STEP16      = 16'(VOL_STEP);

    typedef enum logic [1:0] {IDLE, MUTE_WAIT, APPLY, SETTLE} state_e;

    state_e         state_q, state_d;
    logic [3:0]     osr_sel_q, osr_sel_d;
    logic [3:0]     osr_pending_q, osr_pending_d;
    logic [15:0]    volume_q, volume_d;
    logic [15:0]    vol_target_q, vol_target_d;
    logic           user_mute_q, user_mute_d;
    logic           soft_mute_q, soft_mute_d;
    logic [MCW-1:0] mute_cnt_q, mute_cnt_d;
    logic [SCW-1:0] settle_cnt_q, settle_cnt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           accept;
    logic [3:0]     osr_norm;
    logic [16:0]    vol_ext, tgt_ext;

    assign cfg_ready  = (state_q == IDLE);
    assign accept     = cfg_valid & cfg_ready;
    assign osr_norm   = (cfg_osr > 4'd3) ? 4'd0 : cfg_osr;
    assign vol_ext    = {1'b0, volume_q};
    assign tgt_ext    = {1'b0, vol_target_q};

    assign osr_sel    = osr_sel_q;
    assign volume_q15 = volume_q;
    assign soft_mute  = soft_mute_q;
    assign busy       = busy_q;
    assign done       = done_q;

    // Next-state: sequencer FSM, config capture, volume glide, mute counter.
    always_comb begin
        state_d       = state_q;
        osr_sel_d     = osr_sel_q;
        osr_pending_d = osr_pending_q;
        volume_d      = volume_q;
        vol_target_d  = vol_target_q;
        user_mute_d   = user_mute_q;
        settle_cnt_d  = settle_cnt_q;
        soft_mute_d   = 1'b1;
        done_d        = 1'b0;

        unique case (state_q)
            IDLE: begin
                soft_mute_d = user_mute_q;
                if (accept && (osr_norm != osr_sel_q)) state_d = MUTE_WAIT;
            end
            MUTE_WAIT: begin
                if (mute_cnt_q == RAMP_MAX) state_d = APPLY;
            end
            APPLY: begin
                osr_sel_d    = osr_pending_q;
                settle_cnt_d = SETTLE_LOAD;
                state_d      = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt_q == '0) begin
                    state_d     = IDLE;
                    done_d      = 1'b1;
                    soft_mute_d = user_mute_q;
                end else begin
                    settle_cnt_d = settle_cnt_q - SCW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            vol_target_d  = cfg_volume;
            user_mute_d   = cfg_mute;
            osr_pending_d = osr_norm;
        end

        // Glide uses the pre-accept target; 17-bit compares avoid wrap.
        if (sample_tick) begin
            if (volume_q < vol_target_q)
                volume_d = (vol_ext + STEP17 >= tgt_ext) ? vol_target_q : volume_q + STEP16;
            else if (volume_q > vol_target_q)
                volume_d = (tgt_ext + STEP17 >= vol_ext) ? vol_target_q : volume_q - STEP16;
        end

        // Counter moves in lockstep with soft_mute: it holds how many cycles
        // soft_mute has been continuously high, saturating at RAMP_CYCLES.
        if (!soft_mute_d)               mute_cnt_d = '0;
        else if (mute_cnt_q == RAMP_MAX) mute_cnt_d = mute_cnt_q;
        else                            mute_cnt_d = mute_cnt_q + MCW'(1);

        busy_d = (state_d != IDLE);
    end

    // State registers; reset abandons any sequence in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            osr_sel_q     <= 4'd0;
            osr_pending_q <= 4'd0;
            volume_q      <= RESET_VOL;
            vol_target_q  <= RESET_VOL;
            user_mute_q   <= 1'b0;
            soft_mute_q   <= 1'b0;
            mute_cnt_q    <= '0;
            settle_cnt_q  <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            osr_sel_q     <= osr_sel_d;
            osr_pending_q <= osr_pending_d;
            volume_q      <= volume_d;
            vol_target_q  <= vol_target_d;
            user_mute_q   <= user_mute_d;
            soft_mute_q   <= soft_mute_d;
            mute_cnt_q    <= mute_cnt_d;
            settle_cnt_q  <= settle_cnt_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

endmodule

// File: tb/tb_dsp_cfg_sequencer.sv
// Bench for dsp_cfg_sequencer: random ticks/volumes against a timestamp model.
module tb_dsp_cfg_sequencer;

    localparam int RAMP   = 512;
    localparam int SETTLE = 32;
    localparam int STEP   = 256;

    logic        clk, rst_n;
    logic        cfg_valid, cfg_ready, cfg_mute, sample_tick;
    logic [3:0]  cfg_osr, osr_sel;
    logic [15:0] cfg_volume, volume_q15;
    logic        soft_mute, busy, done;

    dsp_cfg_sequencer #(.RAMP_CYCLES(RAMP), .SETTLE_CYCLES(SETTLE), .VOL_STEP(STEP),
                        .RESET_VOL(16'h7FFF)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_osr(cfg_osr), .cfg_volume(cfg_volume), .cfg_mute(cfg_mute),
        .sample_tick(sample_tick), .osr_sel(osr_sel), .volume_q15(volume_q15),
        .soft_mute(soft_mute), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks, errors;

    // Reference model: outputs derived from edge timestamps of each sequence.
    int cyc, m_since, osr_edge, done_edge;
    int m_osr, m_pend, m_vol, m_tgt;
    bit m_umute, m_soft, m_busy, m_done, m_inseq, m_acc;
    logic [23:0] exp_v;
    logic [23:0] obs_v;
    assign obs_v = {osr_sel, volume_q15, soft_mute, busy, done, cfg_ready};

    localparam logic [23:0] RESET_V = {4'd0, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1};

    task automatic model_reset();
        m_osr = 0; m_pend = 0; m_vol = 32767; m_tgt = 32767;
        m_umute = 0; m_soft = 0; m_busy = 0; m_done = 0; m_inseq = 0; m_acc = 0;
        m_since = -100000;
        exp_v = RESET_V;
    endtask

    // Drive one cycle of inputs (called at a negedge), advance the model for
    // the coming edge, and return at the following negedge.
    task automatic step(input bit valid, input logic [3:0] osr, input logic [15:0] vol,
                        input bit mute, input bit tick);
        int e, n, start;
        bit new_soft;
        cfg_valid = valid; cfg_osr = osr; cfg_volume = vol; cfg_mute = mute; sample_tick = tick;
        e = cyc + 1;
        m_acc = valid && !m_inseq;
        if (tick) begin
            if (m_vol < m_tgt)      m_vol = (m_vol + STEP > m_tgt) ? m_tgt : m_vol + STEP;
            else if (m_vol > m_tgt) m_vol = (m_vol - STEP < m_tgt) ? m_tgt : m_vol - STEP;
        end
        m_done = 0;
        new_soft = m_umute;
        if (m_inseq) begin
            new_soft = 1;
            if (e == osr_edge) m_osr = m_pend;
            if (e == done_edge) begin
                m_done = 1; m_inseq = 0; new_soft = m_umute;
            end
        end
        if (new_soft && !m_soft) m_since = e;
        if (m_acc) begin
            m_tgt = int'(vol); m_umute = mute;
            n = (osr > 3) ? 0 : int'(osr);
            if (n != m_osr) begin
                m_pend = n; m_inseq = 1;
                // osr switches one edge after soft_mute has been high RAMP cycles
                start = new_soft ? m_since : e + 1;
                osr_edge = (start + RAMP + 1 > e + 2) ? start + RAMP + 1 : e + 2;
                done_edge = osr_edge + SETTLE;
            end
        end
        m_soft = new_soft; m_busy = m_inseq; cyc = e;
        exp_v = {4'(m_osr), 16'(m_vol), m_soft, m_busy, m_done, !m_inseq};
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic bit rtick();
        return ($urandom_range(0, 3) == 0);
    endfunction

    task automatic async_reset(input string tag);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (obs_v !== RESET_V) begin
            errors++;
            $display("FAIL %s_async: got %h expected %h", tag, obs_v, RESET_V);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        step(1, 4'd2, 16'h1000, 1, 0);
        for (int i = 0; i < 30; i++) begin
            step(0, 4'd0, 16'h0, 0, rtick());
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL reset_pre: got %h expected %h", obs_v, exp_v); end
        end
        async_reset("reset");
        step(0, 4'd0, 16'h0, 0, 1);
        checks++;
        if (obs_v !== RESET_V) begin errors++; $display("FAIL reset_post: got %h expected %h", obs_v, RESET_V); end
    endtask

    task automatic test_volume_glide();
        int ticks;
        bit tk;
        step(1, 4'd0, 16'h4000, 0, 0);
        checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL glide_accept: got %h expected %h", obs_v, exp_v); end
        ticks = 0;
        for (int i = 0; i < 1000 && ticks < 70; i++) begin
            tk = $urandom_range(0, 1) == 1;
            step(0, 4'd0, 16'h0, 0, tk);
            if (tk) ticks++;
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL glide_cycle: got %h expected %h", obs_v, exp_v); end
            if (tk && ticks == 1) begin
                checks++;
                if (volume_q15 !== 16'h7EFF) begin errors++; $display("FAIL glide_tick1: got %h expected 7eff", volume_q15); end
            end
            if (tk && ticks == 63) begin
                checks++;
                if (volume_q15 !== 16'h40FF) begin errors++; $display("FAIL glide_tick63: got %h expected 40ff", volume_q15); end
            end
            if (tk && ticks >= 64) begin
                checks++;
                if (volume_q15 !== 16'h4000 || busy !== 1'b0) begin
                    errors++; $display("FAIL glide_hold: got vol=%h busy=%b expected 4000/0", volume_q15, busy);
                end
            end
        end
    endtask

    task automatic test_osr_change();
        int n_acc, osr_at, done_at;
        step(1, 4'd1, 16'($urandom), 0, rtick());
        n_acc = cyc; osr_at = -1; done_at = -1;
        checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL osr_accept: got %h expected %h", obs_v, exp_v); end
        for (int i = 0; i < 600; i++) begin
            step(0, 4'd0, 16'h0, 0, rtick());
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL osr_cycle: got %h expected %h", obs_v, exp_v); end
            if (osr_at < 0 && osr_sel === 4'd1) osr_at = cyc;
            if (done === 1'b1) done_at = cyc;
            if (cyc == n_acc + 1) begin
                checks++;
                if (soft_mute !== 1'b1) begin errors++; $display("FAIL osr_mute_n1: got %b expected 1", soft_mute); end
            end
        end
        checks++;
        if (osr_at - n_acc !== RAMP + 2) begin errors++; $display("FAIL osr_latency: got %0d expected %0d", osr_at - n_acc, RAMP + 2); end
        checks++;
        if (done_at - n_acc !== RAMP + SETTLE + 2) begin errors++; $display("FAIL osr_done_latency: got %0d expected %0d", done_at - n_acc, RAMP + SETTLE + 2); end
        checks++;
        if (soft_mute !== 1'b0) begin errors++; $display("FAIL osr_release: got %b expected 0", soft_mute); end
    endtask

    task automatic test_premuted();
        int n_acc, osr_at, done_at;
        step(1, 4'd1, 16'($urandom), 1, rtick());
        for (int i = 0; i < 600; i++) begin
            step(0, 4'd0, 16'h0, 0, rtick());
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL premute_wait: got %h expected %h", obs_v, exp_v); end
        end
        step(1, 4'd3, 16'($urandom), 1, rtick());
        n_acc = cyc; osr_at = -1; done_at = -1;
        for (int i = 0; i < 60; i++) begin
            step(0, 4'd0, 16'h0, 0, rtick());
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL premute_cycle: got %h expected %h", obs_v, exp_v); end
            if (osr_at < 0 && osr_sel === 4'd3) osr_at = cyc;
            if (done === 1'b1) done_at = cyc;
        end
        checks++;
        if (osr_at - n_acc !== 2) begin errors++; $display("FAIL premute_latency: got %0d expected 2", osr_at - n_acc); end
        checks++;
        if (done_at - n_acc !== SETTLE + 2) begin errors++; $display("FAIL premute_done: got %0d expected %0d", done_at - n_acc, SETTLE + 2); end
        checks++;
        if (soft_mute !== 1'b1) begin errors++; $display("FAIL premute_stay_muted: got %b expected 1", soft_mute); end
    endtask

    task automatic test_backpressure();
        int done_at, acc_at, dones;
        logic [15:0] v2;
        v2 = 16'($urandom);
        done_at = -1; acc_at = -1; dones = 0;
        step(1, 4'd0, 16'($urandom), 0, 1);
        for (int i = 0; i < 1200 && acc_at < 0; i++) begin
            step(1, 4'd2, v2, 0, rtick());
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL bp_hold: got %h expected %h", obs_v, exp_v); end
            if (done === 1'b1) begin done_at = cyc; dones++; end
            if (m_acc) acc_at = cyc;
        end
        checks++;
        if (acc_at - done_at !== 1) begin errors++; $display("FAIL bp_accept_edge: got %0d expected 1", acc_at - done_at); end
        for (int i = 0; i < 600; i++) begin
            step(0, 4'd0, 16'h0, 0, rtick());
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL bp_second: got %h expected %h", obs_v, exp_v); end
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 2 || osr_sel !== 4'd2) begin
            errors++; $display("FAIL bp_sequences: got dones=%0d osr=%0d expected 2/2", dones, osr_sel);
        end
    endtask

    task automatic test_reset_mid_seq();
        int dones;
        step(1, 4'd1, 16'($urandom), 0, rtick());
        for (int i = 0; i < 200; i++) begin
            step(0, 4'd0, 16'h0, 0, rtick());
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL midrst_pre: got %h expected %h", obs_v, exp_v); end
        end
        async_reset("midrst");
        step(1, 4'd7, 16'($urandom), 0, rtick());
        for (int i = 0; i < 20; i++) begin
            step(0, 4'd0, 16'h0, 0, rtick());
            checks++;
            if (busy !== 1'b0 || obs_v !== exp_v) begin errors++; $display("FAIL midrst_osr7_idle: got %h expected %h", obs_v, exp_v); end
        end
        step(1, 4'd2, 16'($urandom), 0, rtick());
        for (int i = 0; i < 560; i++) begin
            step(0, 4'd0, 16'h0, 0, rtick());
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL midrst_to2: got %h expected %h", obs_v, exp_v); end
        end
        dones = 0;
        step(1, 4'd7, 16'($urandom), 0, rtick());
        for (int i = 0; i < 560; i++) begin
            step(0, 4'd0, 16'h0, 0, rtick());
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL midrst_osr7_seq: got %h expected %h", obs_v, exp_v); end
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 1 || osr_sel !== 4'd0) begin
            errors++; $display("FAIL midrst_final: got dones=%0d osr=%0d expected 1/0", dones, osr_sel);
        end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        cfg_valid = 0; cfg_osr = 0; cfg_volume = 0; cfg_mute = 0; sample_tick = 0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_volume_glide();
        test_osr_change();
        test_premuted();
        test_backpressure();
        test_reset_mid_seq();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsp_cfg_sequencer.md
Name: dsp_cfg_sequencer

Overview:
Configuration sequencer that sits between the control register file and dsp_engine. It drives dsp_engine's osr_sel, volume_q15 and soft_mute.
- Volume changes are glided one step per input sample to avoid zipper noise.
- OSR changes are sequenced click-free: force soft-mute, wait for the mute ramp to bottom out, switch osr_sel, wait for the interpolator to flush, release mute.
- The control side uses a valid/ready handshake; status pulses report completion.

Parameters:
RAMP_CYCLES, 512, cycles of continuous soft_mute needed for the engine's gain ramp to reach 0 (32767/64 rounded up).
SETTLE_CYCLES, 32, cycles held muted after an osr_sel change (FIR flush). Must be ≥1.
VOL_STEP, 256, maximum volume_q15 change per sample tick (unsigned).
RESET_VOL, 16'h7FFF, reset value of volume target and output.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  new configuration offered
cfg_ready  out  1  sequencer can accept configuration
cfg_osr  in  4  requested OSR code (0=1x,1=4x,2=8x,3=16x; others treated as 0)
cfg_volume  in  16  requested volume, Q1.15
cfg_mute  in  1  requested user mute
sample_tick  in  1  one-cycle pulse per input sample (dsp_engine in_valid)
osr_sel  out  4  to dsp_engine
volume_q15  out  16  to dsp_engine
soft_mute  out  1  to dsp_engine
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when an OSR change sequence completes

Behaviour:
- Reset (async, immediate):
  - osr_sel=0, volume_q15=RESET_VOL, vol_target=RESET_VOL, user_mute=0, soft_mute=0.
  - state=IDLE, mute_cnt=0, settle_cnt=0, busy=0, done=0, cfg_ready=1.
- Reset asserted mid-sequence abandons it; the pending OSR is discarded.
- Registered state: vol_target, user_mute, osr_pending, mute_cnt (saturating, width clog2(RAMP_CYCLES+1)), settle_cnt.
- Accept: cfg_valid & cfg_ready at a rising edge. On accept:
  - vol_target ← cfg_volume.
  - user_mute ← cfg_mute.
  - osr_pending ← cfg_osr normalised (codes >3 become 0).
- cfg_ready is combinational: 1 only in IDLE.
- FSM states: IDLE, MUTE_WAIT, APPLY, SETTLE.
  - IDLE:
    - soft_mute = user_mute.
    - An accept whose normalised osr equals osr_sel stays in IDLE (volume/mute update only).
    - An accept with a differing osr goes to MUTE_WAIT.
  - MUTE_WAIT:
    - soft_mute=1.
    - Go to APPLY at the edge where mute_cnt==RAMP_CYCLES is sampled.
    - If already premuted long enough (mute_cnt saturated on entry), exit after one cycle.
  - APPLY (1 cycle):
    - soft_mute=1.
    - At exit: osr_sel←osr_pending, settle_cnt←SETTLE_CYCLES−1, go to SETTLE.
  - SETTLE:
    - soft_mute=1; settle_cnt decrements each cycle.
    - When settle_cnt==0 is sampled: go to IDLE and assert done for exactly the next cycle.
    - soft_mute then follows user_mute.
- soft_mute is a registered output. mute_cnt increments each cycle soft_mute==1 (saturates at RAMP_CYCLES) and clears to 0 on any cycle soft_mute==0.
- Volume glide (all states):
  - On sample_tick, if volume_q15 < vol_target: volume_q15 ← min(volume_q15+VOL_STEP, vol_target). If greater: volume_q15 ← max(volume_q15−VOL_STEP, vol_target).
  - Unsigned 17-bit intermediate; never overshoots, never wraps.
  - No change without a tick.
- Simultaneous tick and accept: the glide step uses the pre-accept vol_target; the new target takes effect from the next tick.
- Latency, with an unmuted start, from accept edge N:
  - soft_mute=1 from N+1.
  - osr_sel changes at edge N+RAMP_CYCLES+2.
  - done high in the cycle after edge N+RAMP_CYCLES+SETTLE_CYCLES+2.
  - soft_mute releases at that same edge when user_mute=0.
- cfg_valid held while busy is ignored until IDLE; it is accepted at the first IDLE edge.
- busy is registered, equal to (state!=IDLE).

Test Plan:
1. Reset with rst_n pulsed low asynchronously mid-cycle → outputs immediately osr_sel=0, volume_q15=0x7FFF, soft_mute=0, cfg_ready=1, busy=0.
2. Volume glide: accept volume=0x4000 with osr unchanged; 64 sample_ticks → volume_q15 falls 0x7FFF→0x7EFF→… and reaches exactly 0x4000 on tick 64, then holds. No state change, busy=0.
3. OSR change: accept osr=1, mute=0 at edge N → soft_mute=1 at N+1; osr_sel=1 at N+514; done pulses one cycle after edge N+546; soft_mute=0 from then.
4. Premuted OSR change: accept mute=1, wait 600 cycles, then accept osr=3, mute=1 → MUTE_WAIT lasts 1 cycle; osr_sel=3 two edges after accept; soft_mute stays 1 after done.
5. Backpressure: hold cfg_valid with osr=2 during a busy sequence → cfg_ready=0 throughout; accepted on the first IDLE edge; a second full sequence runs.
6. Reset mid-MUTE_WAIT (cycle 200) → osr_sel remains 0, state IDLE, soft_mute=0, pending osr discarded. Invalid cfg_osr=7 then runs a sequence only if osr_sel≠0, ending with osr_sel=0.
